mem_arbiter: RTL and testbench

//  Shares one external memory port between the I-cache refill path and the D-cache refill/writeback path.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one external memory port between the I-cache refill path and the D-cache refill/writeback path.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q;
    logic   d_wen_q;
    logic   d_wins;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;  // 1 when D received the most recent grant

    assign d_wins = d_req && !(i_req && last_d_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if (state_q == IDLE && (i_req || d_req)) begin
            last_d_q <= d_wins;
        end
    end
`else
    assign d_wins = d_req;
`endif

    // NOTE: every register below is sequential state, so it is written with <= only;
    // blocking assignments here would let later statements see same-cycle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            d_wen_q   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            grant     <= 2'b00;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_wins) begin
                        state_q   <= D_BUSY;
                        grant     <= 2'b10;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        d_wen_q   <= d_wen;
                        mem_wen   <= d_wen;
                        mem_ren   <= ~d_wen;
                    end else if (i_req) begin
                        state_q  <= I_BUSY;
                        grant    <= 2'b01;
                        mem_addr <= i_addr;
                        mem_ren  <= 1'b1;
                        mem_wen  <= 1'b0;
                    end
                end
                I_BUSY: begin
                    if (mem_ready) begin
                        mem_ren <= 1'b0;
                        i_rdata <= mem_rdata;
                        i_ack   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                D_BUSY: begin
                    if (mem_ready) begin
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                        if (!d_wen_q) begin
                            d_rdata <= mem_rdata;
                        end
                        d_ack   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Requests are not looked at here; the acked requester drops req meanwhile.
                    grant   <= 2'b00;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of the arbiter and a behavioural memory.
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam logic [DATA_W-1:0] WB_DATA = 128'hDEADBEEF_0011_2233_4455_6677_CAFE_BEEF;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_req = 1'b0;
    addr_t      i_addr = '0;
    logic       i_ack;
    data_t      i_rdata;
    logic       d_req = 1'b0;
    logic       d_wen = 1'b0;
    addr_t      d_addr = '0;
    data_t      d_wdata = '0;
    logic       d_ack;
    data_t      d_rdata;
    logic       mem_ren;
    logic       mem_wen;
    addr_t      mem_addr;
    data_t      mem_wdata;
    logic       mem_ready = 1'b0;
    data_t      mem_rdata = '0;
    logic [1:0] grant;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .grant(grant)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input data_t got, input data_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Behavioural memory: sparse store, untouched blocks read as an address-derived pattern.
    data_t store [addr_t];
    int    mem_lat = 0, mem_cnt = 0, force_lat = 0;

    function automatic data_t mem_default(input addr_t a);
        return {4{32'(a) ^ 32'h5A5A_1234}};
    endfunction

    function automatic data_t mem_read(input addr_t a);
        return store.exists(a) ? store[a] : mem_default(a);
    endfunction

    function automatic data_t rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic addr_t rand_addr();
        return addr_t'($urandom_range(0, 7) << 4);
    endfunction

    // Requester intents and traffic mode.
    bit    auto_mode = 1'b0;
    bit    want_i = 1'b0, want_d = 1'b0, want_d_wen = 1'b0;
    addr_t want_i_addr = '0, want_d_addr = '0;
    data_t want_d_wdata = '0;

    // Transaction-level model: one transaction in flight, a transfer phase then one ack cycle.
    typedef enum {P_IDLE, P_XFER, P_ACK} phase_e;
    typedef struct {
        bit    is_d;
        bit    wen;
        addr_t addr;
        data_t wdata;
    } txn_t;

    phase_e phase = P_IDLE;
    txn_t   cur = '{default: '0};
`ifdef MEM_ARB_RR_EN
    bit     last_d = 1'b0;
`endif
    data_t  exp_i_rdata = '0, exp_d_rdata = '0;

    logic [1:0] grant_log[$];
    logic [1:0] prev_grant = 2'b00;
    int cyc = 0, i_raise_cyc = 0, d_raise_cyc = 0, i_ack_lat = 0, d_ack_lat = 0;
    int ren_cycles = 0, wen_cycles = 0, i_ack_cycles = 0, d_ack_cycles = 0;

    task automatic clear_stats();
        grant_log.delete();
        ren_cycles = 0; wen_cycles = 0; i_ack_cycles = 0; d_ack_cycles = 0;
    endtask

    task automatic model_reset();
        phase = P_IDLE;
`ifdef MEM_ARB_RR_EN
        last_d = 1'b0;
`endif
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        mem_cnt = 0;
        mem_ready = 1'b0;
        prev_grant = 2'b00;
    endtask

    task automatic check_reset_values();
        check("rst_grant", grant, 2'b00);
        check("rst_mem_ren", mem_ren, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_i_ack", i_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
    endtask

    task automatic check_outputs();
        bit xfer, ackc, wr;
        logic [1:0] g;
        xfer = (phase == P_XFER);
        ackc = (phase == P_ACK);
        wr   = cur.is_d && cur.wen;
        g    = (phase == P_IDLE) ? 2'b00 : (cur.is_d ? 2'b10 : 2'b01);
        check("grant", grant, g);
        check("mem_ren", mem_ren, xfer && !wr);
        check("mem_wen", mem_wen, xfer && wr);
        check("strobe_excl", mem_ren & mem_wen, 0);
        if (phase != P_IDLE) check("mem_addr", mem_addr, cur.addr);
        if (xfer && wr) check("mem_wdata", mem_wdata, cur.wdata);
        check("i_ack", i_ack, ackc && !cur.is_d);
        check("d_ack", d_ack, ackc && cur.is_d);
        check("i_rdata", i_rdata, exp_i_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);
        ren_cycles   += int'(mem_ren);
        wen_cycles   += int'(mem_wen);
        i_ack_cycles += int'(i_ack);
        d_ack_cycles += int'(d_ack);
        if (i_ack) i_ack_lat = cyc - i_raise_cyc;
        if (d_ack) d_ack_lat = cyc - d_raise_cyc;
        if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
        prev_grant = grant;
    endtask

    // Runs at the falling edge: drive requesters and memory, then advance the model
    // across the coming rising edge using exactly the inputs the DUT will sample.
    task automatic drive_and_advance();
        bit take_d;
        if (i_ack) begin
            i_req = 1'b0;
        end else if (!i_req && (want_i || (auto_mode && $urandom_range(0, 3) == 0))) begin
            i_addr = want_i ? want_i_addr : rand_addr();
            i_req = 1'b1;
            want_i = 1'b0;
            i_raise_cyc = cyc;
        end
        if (d_ack) begin
            d_req = 1'b0;
        end else if (!d_req && (want_d || (auto_mode && $urandom_range(0, 3) == 0))) begin
            if (want_d) begin
                d_addr = want_d_addr; d_wen = want_d_wen; d_wdata = want_d_wdata;
            end else begin
                d_addr = rand_addr(); d_wen = ($urandom_range(0, 1) == 1); d_wdata = rand_data();
            end
            d_req = 1'b1;
            want_d = 1'b0;
            d_raise_cyc = cyc;
        end

        if (mem_ren || mem_wen) begin
            if (mem_cnt == 0) mem_lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_ready = 1'b1;
                mem_cnt = 0;
                if (mem_wen) begin
                    store[mem_addr] = mem_wdata;
                    mem_rdata = rand_data();
                end else begin
                    mem_rdata = mem_read(mem_addr);
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = rand_data();
            end
        end else begin
            // Stray ready pulses outside a transfer must be ignored.
            mem_ready = ($urandom_range(0, 7) == 0);
            mem_rdata = rand_data();
        end

        case (phase)
            P_IDLE: begin
                if (i_req || d_req) begin
`ifdef MEM_ARB_RR_EN
                    take_d = (i_req && d_req) ? !last_d : d_req;
                    last_d = take_d;
`else
                    take_d = d_req;
`endif
                    cur.is_d  = take_d;
                    cur.wen   = take_d && d_wen;
                    cur.addr  = take_d ? d_addr : i_addr;
                    cur.wdata = d_wdata;
                    phase = P_XFER;
                end
            end
            P_XFER: begin
                if (mem_ready) begin
                    if (!cur.wen) begin
                        if (cur.is_d) exp_d_rdata = mem_read(cur.addr);
                        else          exp_i_rdata = mem_read(cur.addr);
                    end
                    phase = P_ACK;
                end
            end
            default: phase = P_IDLE;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        check_outputs();
        drive_and_advance();
    endtask

    task automatic run_until_quiet(input int budget);
        int  n;
        bit  quiet;
        n = 0;
        quiet = 1'b0;
        while (!quiet && n < budget) begin
            cycle();
            n++;
            quiet = (phase == P_IDLE) && !i_req && !d_req && !want_i && !want_d;
        end
        check("quiet_timeout", quiet, 1);
    endtask

    task automatic run_until_grants(input int k, input int budget);
        int n;
        n = 0;
        while (grant_log.size() < k && n < budget) begin
            cycle();
            n++;
        end
        check("grant_timeout", grant_log.size() >= k, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        model_reset();
        drive_and_advance();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        model_reset();
        drive_and_advance();

        // I read alone, ready three cycles after the strobe rises.
        clear_stats();
        force_lat = 3;
        want_i_addr = 28'h0000010;
        want_i = 1'b1;
        run_until_quiet(50);
        check("t1_grant", grant_log[0], 2'b01);
        check("t1_ren_cycles", ren_cycles, 3);
        check("t1_ack_cycles", i_ack_cycles, 1);
        check("t1_ack_latency", i_ack_lat, 4);
        check("t1_i_rdata", i_rdata, mem_default(28'h0000010));

        // D writeback, ready in the first busy cycle.
        clear_stats();
        force_lat = 1;
        want_d_addr = 28'h0000020;
        want_d_wen = 1'b1;
        want_d_wdata = WB_DATA;
        want_d = 1'b1;
        run_until_quiet(50);
        check("t2_grant", grant_log[0], 2'b10);
        check("t2_wen_cycles", wen_cycles, 1);
        check("t2_ren_cycles", ren_cycles, 0);
        check("t2_ack_latency", d_ack_lat, 2);
        check("t2_d_rdata_kept", d_rdata, 0);

        // D read of the written block; I arrives mid-transfer and must wait.
        clear_stats();
        force_lat = 4;
        want_d_addr = 28'h0000020;
        want_d_wen = 1'b0;
        want_d = 1'b1;
        run_until_grants(1, 20);
        cycle();
        cycle();
        want_i_addr = 28'h0000040;
        want_i = 1'b1;
        run_until_quiet(60);
        check("t4_grant_count", grant_log.size(), 2);
        check("t4_first_grant", grant_log[0], 2'b10);
        check("t4_second_grant", grant_log[1], 2'b01);
        check("t4_d_rdata", d_rdata, WB_DATA);
        check("t4_i_rdata", i_rdata, mem_default(28'h0000040));

        // Simultaneous requests twice back to back, from the reset arbitration state.
        apply_reset();
        clear_stats();
        force_lat = 0;
        want_i_addr = 28'h0000050;
        want_d_addr = 28'h0000060;
        want_d_wen = 1'b0;
        want_i = 1'b1;
        want_d = 1'b1;
        run_until_grants(1, 20);
        want_d_addr = 28'h0000070;
        want_d = 1'b1;
        run_until_grants(2, 40);
        run_until_quiet(100);
        check("t3_grant_count", grant_log.size(), 3);
        check("t3_first_grant", grant_log[0], 2'b10);
`ifdef MEM_ARB_RR_EN
        check("t3_second_grant", grant_log[1], 2'b01);
`else
        check("t3_second_grant", grant_log[1], 2'b10);
`endif

        // Asynchronous reset while I is mid-transfer; the held request is served afresh.
        clear_stats();
        force_lat = 6;
        want_i_addr = 28'h0000030;
        want_i = 1'b1;
        run_until_grants(1, 20);
        cycle();
        cycle();
        check("t5_strobe_before_rst", mem_ren, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_ren", mem_ren, 0);
        check("t5_async_grant", grant, 2'b00);
        check("t5_async_ack", i_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs();
        drive_and_advance();
        run_until_quiet(60);
        check("t5_grant_count", grant_log.size(), 2);
        check("t5_ack_cycles", i_ack_cycles, 1);
        check("t5_i_rdata", i_rdata, mem_default(28'h0000030));

        // Randomized traffic from both requesters with random memory latency.
        force_lat = 0;
        auto_mode = 1'b1;
        repeat (3000) cycle();
        auto_mode = 1'b0;
        run_until_quiet(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
